rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one resource among requesters 0-3. It holds the winner's 2-bit index in a register and drives the one-hot grant vector from that index through a 2-to-4 decode, using the same mapping as the team's 2x4 decoder. Grants are held while the owner keeps its request asserted. A hold-limit counter preempts an owner that monopolises the resource while others wait.

---
 rtl/rr_arbiter4.sv | 128 ++++++++++++
 tb/tb_rr_arbiter4.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a hold-limit preemption.
// The winner's index is held in a register. The one-hot grant is a registered
// 2-to-4 decode of that index, qualified by the GRANT state. Every release,
// voluntary or forced, is followed by one dead GAP cycle before the next owner.
// Parameter legality: 1 <= MAX_HOLD <= 255 and 2**CNT_W > MAX_HOLD.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             preempt_reg, preempt_next;
  logic [3:0]       gnt_reg, gnt_next;

  logic [3:0]       rot_req;        // req rotated so bit 0 is the ptr position
  logic [3:0]       owner_mask;     // one-hot of the current owner index
  logic [1:0]       win_off;
  logic [1:0]       win_idx;
  logic             any_req;
  logic             owner_req;
  logic             others_pending;

  // Rotation of the request vector, owner mask and next-grant decode
  // (index 0 -> 4'b0001 ... index 3 -> 4'b1000).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign rot_req[gi]    = req[ptr_reg + 2'(gi)];
      assign owner_mask[gi] = (idx_reg == 2'(gi));
      assign gnt_next[gi]   = (state_next == GRANT) && (idx_next == 2'(gi));
    end
  endgenerate

  // Lowest rotated offset with a pending request wins.
  always_comb begin
    win_off = 2'd0;
    if (rot_req[0])      win_off = 2'd0;
    else if (rot_req[1]) win_off = 2'd1;
    else if (rot_req[2]) win_off = 2'd2;
    else if (rot_req[3]) win_off = 2'd3;
  end

  assign win_idx        = ptr_reg + win_off;
  assign any_req        = |req;
  assign owner_req      = |(req & owner_mask);
  assign others_pending = |(req & ~owner_mask);

  // Next-state logic: arbitrate in IDLE/GAP, release or hold in GRANT.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    preempt_next = 1'b0;
    case (state_reg)
      IDLE, GAP: begin
        if (any_req) begin
          state_next = GRANT;
          idx_next   = win_idx;
          cnt_next   = CNT_ONE;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Voluntary release wins even when the limit is reached this edge.
          state_next = GAP;
          ptr_next   = idx_reg + 2'd1;
        end else if ((cnt_reg == HOLD_MAX) && others_pending) begin
          state_next   = GAP;
          ptr_next     = idx_reg + 2'd1;
          preempt_next = 1'b1;
        end else if (cnt_reg != HOLD_MAX) begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= 2'd0;
      idx_reg     <= 2'd0;
      cnt_reg     <= '0;
      preempt_reg <= 1'b0;
      gnt_reg     <= 4'b0000;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      preempt_reg <= preempt_next;
      gnt_reg     <= gnt_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_idx = idx_reg;
  assign busy    = (state_reg == GRANT);
  assign preempt = preempt_reg;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed scenarios plus randomized requests, all checked
// every cycle against a behavioural owner/priority model of the arbiter.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       preempt;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: who owns the resource, how long it has held it, and
  // which requester has top priority next. "No owner" covers IDLE and GAP.
  int         m_owner = -1;
  int         m_last  = 0;
  int         m_held  = 0;
  int         m_ptr   = 0;
  bit         m_pre   = 1'b0;
  logic [3:0] own_mask;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_last  = 0;
      m_held  = 0;
      m_ptr   = 0;
      m_pre   = 1'b0;
    end else if (m_owner >= 0) begin
      m_pre    = 1'b0;
      own_mask = 4'(1 << m_owner);
      if (req[m_owner] == 1'b0) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else if (m_held >= MAX_HOLD && (req & ~own_mask) != 4'b0000) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_pre   = 1'b1;
      end else begin
        m_held = m_held + 1;
      end
    end else begin
      m_pre = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_last  = m_owner;
          m_held  = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_gnt", {4'b0, gnt}, (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00);
      chk("model_busy", {7'b0, busy}, {7'b0, (m_owner >= 0)});
      chk("model_preempt", {7'b0, preempt}, {7'b0, m_pre});
      if (m_owner >= 0) chk("model_gnt_idx", {6'b0, gnt_idx}, 8'(m_last));
      if (busy && !prev_busy) $display("t=%0t grant -> requester %0d (req=%b)", $time, gnt_idx, req);
      prev_busy = busy;
    end
  end

  task automatic step(input logic [3:0] r);
    req = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] r;
  logic [3:0] exp_g;

  initial begin
    @(negedge clk);
    do_reset();
    cmp_en = 1'b1;
    $display("scenario: reset values");
    chk("reset_gnt", {4'b0, gnt}, 8'h00);
    chk("reset_busy", {7'b0, busy}, 8'h00);
    chk("reset_preempt", {7'b0, preempt}, 8'h00);

    $display("scenario: basic grant");
    step(4'b0001);
    chk("basic_gnt", {4'b0, gnt}, 8'h01);
    chk("basic_busy", {7'b0, busy}, 8'h01);
    step(4'b0001);
    step(4'b0001);
    chk("basic_hold", {4'b0, gnt}, 8'h01);
    step(4'b0000);
    chk("basic_gap_gnt", {4'b0, gnt}, 8'h00);
    chk("basic_gap_preempt", {7'b0, preempt}, 8'h00);
    step(4'b0000);
    chk("basic_idle_gnt", {4'b0, gnt}, 8'h00);

    $display("scenario: full contention");
    do_reset();
    for (int i = 0; i < 21; i++) begin
      step(4'b1111);
      exp_g = ((i % 5) == 4) ? 4'b0000 : 4'(1 << ((i / 5) % 4));
      chk("contend_gnt", {4'b0, gnt}, {4'b0, exp_g});
      chk("contend_preempt", {7'b0, preempt}, {7'b0, ((i % 5) == 4)});
    end

    $display("scenario: sole requester");
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b0100);
      chk("sole_gnt", {4'b0, gnt}, 8'h04);
      chk("sole_preempt", {7'b0, preempt}, 8'h00);
    end

    $display("scenario: rotation after voluntary release");
    do_reset();
    step(4'b0001);
    step(4'b0001);
    step(4'b0010);
    chk("rot_gap", {4'b0, gnt}, 8'h00);
    step(4'b0011);
    chk("rot_next", {4'b0, gnt}, 8'h02);

    $display("scenario: limit and release on the same edge");
    do_reset();
    for (int i = 0; i < MAX_HOLD; i++) step(4'b0011);
    chk("sim_owner", {4'b0, gnt}, 8'h01);
    step(4'b0010);
    chk("sim_gap_gnt", {4'b0, gnt}, 8'h00);
    chk("sim_gap_preempt", {7'b0, preempt}, 8'h00);
    step(4'b0010);
    chk("sim_next", {4'b0, gnt}, 8'h02);

    $display("scenario: reset mid-grant");
    do_reset();
    step(4'b0010);
    step(4'b0000);
    step(4'b0100);
    step(4'b0100);
    chk("rstmid_owner", {4'b0, gnt}, 8'h04);
    rst = 1'b1;
    step(4'b0100);
    chk("rstmid_gnt", {4'b0, gnt}, 8'h00);
    chk("rstmid_busy", {7'b0, busy}, 8'h00);
    rst = 1'b0;
    step(4'b1010);
    chk("rstmid_next", {4'b0, gnt}, 8'h02);

    $display("scenario: randomized requests");
    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      rst = ($urandom_range(0, 199) == 0);
      step(r);
    end
    rst = 1'b0;
    repeat (3) step(4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
